// File: rtl/trap_ctrl_if.sv
// CSR-file secondary write port plus the CSR read-back values the trap
// sequencer needs.
//   csr_we_o/csr_waddr_o/csr_wdata_o : write strobe, address, data (to CSR file)
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i : current CSR values (from CSR file)
interface trap_ctrl_if;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;

  // Trap sequencer side
  modport master (
    output csr_we_o, csr_waddr_o, csr_wdata_o,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i
  );

  // CSR register file side
  modport slave (
    input  csr_we_o, csr_waddr_o, csr_wdata_o,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Detects ecall/ebreak/mret in decode and
// accepted external interrupts, stalls the pipeline, writes mepc, mcause
// and mstatus through the CSR secondary port, then redirects fetch.
//   clk_i, rst_ni           : clock, async active-low reset
//   inst_i, inst_addr_i     : decode instruction and its PC
//   int_flag_i              : external interrupt lines
//   jump_flag_i/jump_addr_i : ex-stage redirect in flight
//   hold_flag_i             : pipeline already stalled elsewhere
//   global_int_en_i         : mstatus.MIE
//   csr_if                  : CSR write port / CSR read values
//   hold_flag_o             : stall request
//   int_assert_o/int_addr_o : one-cycle fetch redirect and target
module trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3,
  parameter logic [31:0] INT_CAUSE    = 32'h8000_0007
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  inst_i,
  input  logic [31:0]  inst_addr_i,
  input  logic [7:0]   int_flag_i,
  input  logic         jump_flag_i,
  input  logic [31:0]  jump_addr_i,
  input  logic         hold_flag_i,
  input  logic         global_int_en_i,
  trap_ctrl_if.master  csr_if,
  output logic         hold_flag_o,
  output logic         int_assert_o,
  output logic [31:0]  int_addr_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_ASSERT,
    S_MRET
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic              detect_en;
  logic              detect;
  logic [XLEN-1:0]   ms;

  // State and latched trap context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Detection, next state and output decode
  always_comb begin
    state_d            = state_q;
    cause_d            = cause_q;
    epc_d              = epc_q;
    detect             = 1'b0;
    csr_if.csr_we_o    = 1'b0;
    csr_if.csr_waddr_o = '0;
    csr_if.csr_wdata_o = '0;
    int_assert_o       = 1'b0;
    int_addr_o         = '0;
    ms                 = csr_if.csr_mstatus_i;

    // rst_ni gating keeps the combinational hold low while reset is held
    detect_en = rst_ni && (state_q == S_IDLE) && !hold_flag_i;

    case (state_q)
      S_IDLE: begin
        if (detect_en) begin
          if ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK)) begin
            detect  = 1'b1;
            cause_d = (inst_i == INST_ECALL) ? ECALL_CAUSE : EBREAK_CAUSE;
            // A taken branch in ex means decode holds a squashed slot; the
            // trapping instruction sits just before the branch target.
            epc_d   = jump_flag_i ? (jump_addr_i - XLEN'(4)) : inst_addr_i;
            state_d = S_W_MEPC;
          end else if (inst_i == INST_MRET) begin
            detect  = 1'b1;
            state_d = S_MRET;
          end else if ((|int_flag_i) && global_int_en_i) begin
            detect  = 1'b1;
            cause_d = INT_CAUSE;
            // Interrupt resumes at the pending redirect target, unmodified
            epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
            state_d = S_W_MEPC;
          end
        end
      end
      S_W_MEPC: begin
        csr_if.csr_we_o    = 1'b1;
        csr_if.csr_waddr_o = XLEN'(CSR_MEPC);
        csr_if.csr_wdata_o = epc_q;
        state_d            = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        csr_if.csr_we_o    = 1'b1;
        csr_if.csr_waddr_o = XLEN'(CSR_MCAUSE);
        csr_if.csr_wdata_o = cause_q;
        state_d            = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        csr_if.csr_we_o    = 1'b1;
        csr_if.csr_waddr_o = XLEN'(CSR_MSTATUS);
        csr_if.csr_wdata_o = {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
        state_d            = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_if.csr_mtvec_i;
        state_d      = S_IDLE;
      end
      S_MRET: begin
        // MIE <= MPIE, MPIE <= 1, redirect in the same cycle
        csr_if.csr_we_o    = 1'b1;
        csr_if.csr_waddr_o = XLEN'(CSR_MSTATUS);
        csr_if.csr_wdata_o = {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
        int_assert_o       = 1'b1;
        int_addr_o         = csr_if.csr_mepc_i;
        state_d            = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    hold_flag_o = (state_q != S_IDLE) || detect;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table of scenarios expanded into
// per-cycle expected outputs on a scoreboard queue, plus hand-written
// sequences for hold, reset-abort and masked pending interrupts.
module tb_trap_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] INTC   = 32'h8000_0007;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] inst, pc, ja;
  logic [7:0]  intf;
  logic        jf, hold_in, mie;
  logic [31:0] mstatus, mtvec, mepc;
  logic        hold_o, asrt_o;
  logic [31:0] addr_o;

  trap_ctrl_if csr_bus ();
  assign csr_bus.csr_mtvec_i   = mtvec;
  assign csr_bus.csr_mepc_i    = mepc;
  assign csr_bus.csr_mstatus_i = mstatus;

  trap_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .inst_i         (inst),
    .inst_addr_i    (pc),
    .int_flag_i     (intf),
    .jump_flag_i    (jf),
    .jump_addr_i    (ja),
    .hold_flag_i    (hold_in),
    .global_int_en_i(mie),
    .csr_if         (csr_bus),
    .hold_flag_o    (hold_o),
    .int_assert_o   (asrt_o),
    .int_addr_o     (addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        hold;
    logic        asrt;
    logic [31:0] addr;
  } rec_t;

  // kind: 0 = no action, 1 = trap, 2 = mret
  typedef struct {
    int          kind;
    logic [31:0] inst, pc;
    logic [7:0]  intf;
    logic        jf;
    logic [31:0] ja;
    logic        mie;
    logic [31:0] ms, mtvec, mepc;
    logic [31:0] exp_epc, exp_cause, exp_ms, exp_redir;
  } scn_t;

  rec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  scn_t scns[11];

  function automatic rec_t mk(string tag, logic we, logic [31:0] wa, logic [31:0] wd,
                              logic h, logic a, logic [31:0] ad);
    rec_t r;
    r.tag = tag; r.we = we; r.waddr = wa; r.wdata = wd;
    r.hold = h; r.asrt = a; r.addr = ad;
    return r;
  endfunction

  function automatic scn_t ms_scn(int k, logic [31:0] i, logic [31:0] p, logic [7:0] f,
                                  logic j, logic [31:0] a, logic m, logic [31:0] s,
                                  logic [31:0] tv, logic [31:0] ep, logic [31:0] e_epc,
                                  logic [31:0] e_cause, logic [31:0] e_ms, logic [31:0] e_rd);
    scn_t r;
    r.kind = k; r.inst = i; r.pc = p; r.intf = f; r.jf = j; r.ja = a; r.mie = m;
    r.ms = s; r.mtvec = tv; r.mepc = ep;
    r.exp_epc = e_epc; r.exp_cause = e_cause; r.exp_ms = e_ms; r.exp_redir = e_rd;
    return r;
  endfunction

  // Scoreboard consumer: compare one expected record per cycle
  always @(negedge clk) begin
    rec_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (csr_bus.csr_we_o !== e.we || csr_bus.csr_waddr_o !== e.waddr ||
          csr_bus.csr_wdata_o !== e.wdata || hold_o !== e.hold ||
          asrt_o !== e.asrt || addr_o !== e.addr) begin
        n_fail++;
        $display("FAIL %s: got we=%0b waddr=%h wdata=%h hold=%0b assert=%0b addr=%h, expected we=%0b waddr=%h wdata=%h hold=%0b assert=%0b addr=%h",
                 e.tag, csr_bus.csr_we_o, csr_bus.csr_waddr_o, csr_bus.csr_wdata_o,
                 hold_o, asrt_o, addr_o, e.we, e.waddr, e.wdata, e.hold, e.asrt, e.addr);
      end
    end
  end

  // Push expectation for the current cycle, then advance to just after the next edge
  task automatic cyc(input rec_t e);
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst = NOP; intf = 8'h0; jf = 1'b0; ja = 32'h0; hold_in = 1'b0;
  endtask

  task automatic trap_tail(string t, logic [31:0] epc, logic [31:0] cause,
                           logic [31:0] msw, logic [31:0] rd);
    cyc(mk({t, "_mepc"},    1'b1, 32'h341, epc,   1'b1, 1'b0, 32'h0));
    cyc(mk({t, "_mcause"},  1'b1, 32'h342, cause, 1'b1, 1'b0, 32'h0));
    cyc(mk({t, "_mstatus"}, 1'b1, 32'h300, msw,   1'b1, 1'b0, 32'h0));
    cyc(mk({t, "_assert"},  1'b0, 32'h0,   32'h0, 1'b1, 1'b1, rd));
  endtask

  task automatic run_scn(int idx, scn_t s);
    string t;
    t = $sformatf("scn%0d", idx);
    inst = s.inst; pc = s.pc; intf = s.intf; jf = s.jf; ja = s.ja; hold_in = 1'b0;
    mie = s.mie; mstatus = s.ms; mtvec = s.mtvec; mepc = s.mepc;
    if (s.kind == 0) begin
      cyc(mk({t, "_none"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    end else if (s.kind == 1) begin
      cyc(mk({t, "_detect"}, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
      idle_inputs();
      trap_tail(t, s.exp_epc, s.exp_cause, s.exp_ms, s.exp_redir);
    end else begin
      cyc(mk({t, "_detect"}, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
      idle_inputs();
      cyc(mk({t, "_mret"}, 1'b1, 32'h300, s.exp_ms, 1'b1, 1'b1, s.exp_redir));
    end
    idle_inputs();
    cyc(mk({t, "_idle"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t z;
    z = mk("zero", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    //             kind inst    pc         intf  jf  ja          mie  ms            mtvec         mepc        epc           cause         ms_wr         redir
    scns[0]  = ms_scn(1, ECALL,  32'h100, 8'h00, 0, 32'h0,    0, 32'h8,         32'h200,      32'h0,      32'h100,      32'd11,       32'h80,       32'h200);
    scns[1]  = ms_scn(1, NOP,    32'h500, 8'h01, 1, 32'h40,   1, 32'h8,         32'h200,      32'h0,      32'h40,       INTC,         32'h80,       32'h200);
    scns[2]  = ms_scn(0, NOP,    32'h500, 8'h01, 1, 32'h40,   0, 32'h8,         32'h200,      32'h0,      32'h0,        32'h0,        32'h0,        32'h0);
    scns[3]  = ms_scn(2, MRET,   32'h10,  8'h00, 0, 32'h0,    1, 32'h80,        32'h200,      32'h104,    32'h0,        32'h0,        32'h88,       32'h104);
    scns[4]  = ms_scn(1, EBREAK, 32'h20,  8'h00, 1, 32'h0,    1, 32'h8,         32'h200,      32'h0,      32'hFFFF_FFFC, 32'd3,       32'h80,       32'h200);
    scns[5]  = ms_scn(1, ECALL,  32'h50,  8'h00, 1, 32'h1000, 0, 32'hFFFF_FF7F, 32'h8000_0000, 32'h0,     32'hFFC,      32'd11,       32'hFFFF_FFF7, 32'h8000_0000);
    scns[6]  = ms_scn(1, ECALL,  32'h300, 8'h80, 0, 32'h0,    1, 32'h8,         32'h200,      32'h0,      32'h300,      32'd11,       32'h80,       32'h200);
    scns[7]  = ms_scn(2, MRET,   32'h30,  8'h00, 0, 32'h0,    0, 32'h8,         32'h200,      32'h2000,   32'h0,        32'h0,        32'h80,       32'h2000);
    scns[8]  = ms_scn(1, NOP,    32'h600, 8'h10, 0, 32'h0,    1, 32'hAA,        32'h300,      32'h0,      32'h600,      INTC,         32'hA2,       32'h300);
    scns[9]  = ms_scn(2, MRET,   32'h40,  8'h01, 0, 32'h0,    1, 32'h80,        32'h200,      32'h104,    32'h0,        32'h0,        32'h88,       32'h104);
    scns[10] = ms_scn(0, NOP,    32'h44,  8'h00, 0, 32'h0,    1, 32'h8,         32'h200,      32'h0,      32'h0,        32'h0,        32'h0,        32'h0);

    rst_ni = 1'b0; idle_inputs(); pc = 32'h0; mie = 1'b0;
    mstatus = 32'h8; mtvec = 32'h200; mepc = 32'h0;
    @(posedge clk); #1;
    inst = ECALL;  // must not raise hold while reset is held
    cyc(mk("reset0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    idle_inputs();
    cyc(mk("reset1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    rst_ni = 1'b1;
    cyc(mk("post_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));

    for (int i = 0; i < 11; i++) run_scn(i, scns[i]);

    // ebreak held off by an external stall for three cycles
    inst = EBREAK; pc = 32'h700; hold_in = 1'b1; mstatus = 32'h8; mtvec = 32'h200;
    for (int k = 0; k < 3; k++)
      cyc(mk($sformatf("held%0d", k), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    hold_in = 1'b0;
    cyc(mk("held_detect", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    idle_inputs();
    trap_tail("held", 32'h700, 32'd3, 32'h80, 32'h200);
    cyc(mk("held_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));

    // reset asserted during W_MCAUSE abandons the sequence
    inst = ECALL; pc = 32'h800;
    cyc(mk("rst_detect", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    idle_inputs();
    cyc(mk("rst_mepc", 1'b1, 32'h341, 32'h800, 1'b1, 1'b0, 32'h0));
    rst_ni = 1'b0;
    cyc(mk("rst_mid", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    rst_ni = 1'b1;
    cyc(mk("rst_after0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    cyc(mk("rst_after1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));

    // ecall beats interrupt; interrupt stays pending but MIE now cleared
    inst = ECALL; pc = 32'h900; intf = 8'h01; mie = 1'b1;
    cyc(mk("pend_detect", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0));
    inst = NOP; mie = 1'b0; intf = 8'hFF;
    trap_tail("pend", 32'h900, 32'd11, 32'h80, 32'h200);
    cyc(mk("pend_masked", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    idle_inputs();
    cyc(z);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
